// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle for sync_fifo_flags.
//   master : producer/consumer side (drives wdata/winc/rinc/clr_err, observes data and flags)
//   slave  : FIFO side (receives requests, drives rdata, flags, count and error flags)
interface sync_fifo_flags_if #(
    parameter int DATASIZE = 8,
    parameter int ASIZE    = 4
);
    logic [DATASIZE-1:0] wdata;
    logic                winc;
    logic                rinc;
    logic                clr_err;
    logic [DATASIZE-1:0] rdata;
    logic                wfull;
    logic                rempty;
    logic                afull;
    logic                aempty;
    logic [ASIZE:0]      count;
    logic                overflow;
    logic                underflow;

    modport master (
        output wdata, winc, rinc, clr_err,
        input  rdata, wfull, rempty, afull, aempty, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, clr_err,
        output rdata, wfull, rempty, afull, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// standard or first-word-fall-through read mode and sticky error flags.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : sync_fifo_flags_if.slave (write/read requests, data, flags, count, errors)
module sync_fifo_flags #(
    parameter int DATASIZE   = 8,
    parameter int ASIZE      = 4,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sync_fifo_flags_if.slave      bus
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_LVL);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_LVL);

    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("sync_fifo_flags: AFULL_LVL=%0d outside 1..%0d", AFULL_LVL, DEPTH);
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_flags: AEMPTY_LVL=%0d outside 0..%0d", AEMPTY_LVL, DEPTH - 1);
    end

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]      wptr;
    logic [ASIZE:0]      rptr;
    logic [ASIZE:0]      cnt;
    logic [ASIZE-1:0]    waddr;
    logic [ASIZE-1:0]    raddr;
    logic                full;
    logic                empty;
    logic                wr_ok;
    logic                rd_ok;
    logic                ovf;
    logic                unf;

    assign waddr = wptr[ASIZE-1:0];
    assign raddr = rptr[ASIZE-1:0];

    // Extra pointer MSB distinguishes full (same address, different lap) from empty.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ASIZE] != rptr[ASIZE]) && (waddr == raddr);

    assign wr_ok = bus.winc && !full;
    assign rd_ok = bus.rinc && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
            else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[waddr] <= wdata_w();
    end

    function automatic logic [DATASIZE-1:0] wdata_w();
        return bus.wdata;
    endfunction

    // A new error in the same cycle as clr_err wins, so the flag stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (ovf && !bus.clr_err) || (bus.winc && full);
            unf <= (unf && !bus.clr_err) || (bus.rinc && empty);
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word visible directly; meaningless while empty.
        assign bus.rdata = mem[raddr];
    end else begin : g_std
        logic [DATASIZE-1:0] rdata_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     rdata_q <= '0;
            else if (rd_ok) rdata_q <= mem[raddr];
        end
        assign bus.rdata = rdata_q;
    end

    assign bus.wfull     = full;
    assign bus.rempty    = empty;
    assign bus.afull     = (cnt >= AFULL_C);
    assign bus.aempty    = (cnt <= AEMPTY_C);
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;
endmodule
